wbuf: RTL and testbench

//   Posted-store write buffer between the datapath store path and the data memory (dm).

---
 rtl/wbuf_if.sv | 40 ++++
 rtl/wbuf.sv | 114 +++++++++++
 tb/tb_wbuf.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wbuf_if.sv
// Store-path and dm-side bus of the posted-store write buffer.
// Latency: none; this file only bundles the signals.
// Backpressure: Full/Overflow are returned to the store path; dm paces the buffer with DrainEn.
// Ports: store push (Push/PushPc/PushAddr/PushData), drain enable, load lookup address;
//        status flags, dm write port (MemWrite/Addr/Wdata/pc), forwarding result (LdHit/LdData).
interface wbuf_if;
    logic        wbuf_Push;
    logic [31:0] wbuf_PushPc;
    logic [31:0] wbuf_PushAddr;
    logic [31:0] wbuf_PushData;
    logic        wbuf_DrainEn;
    logic [31:0] wbuf_LdAddr;
    logic        wbuf_Full;
    logic        wbuf_Empty;
    logic        wbuf_Overflow;
    logic        wbuf_MemWrite;
    logic [31:0] wbuf_Addr;
    logic [31:0] wbuf_Wdata;
    logic [31:0] wbuf_pc;
    logic        wbuf_LdHit;
    logic [31:0] wbuf_LdData;

    // Datapath / dm side: drives requests, observes buffer state.
    modport master (
        output wbuf_Push, wbuf_PushPc, wbuf_PushAddr, wbuf_PushData,
        output wbuf_DrainEn, wbuf_LdAddr,
        input  wbuf_Full, wbuf_Empty, wbuf_Overflow,
        input  wbuf_MemWrite, wbuf_Addr, wbuf_Wdata, wbuf_pc,
        input  wbuf_LdHit, wbuf_LdData
    );

    // Write buffer side.
    modport slave (
        input  wbuf_Push, wbuf_PushPc, wbuf_PushAddr, wbuf_PushData,
        input  wbuf_DrainEn, wbuf_LdAddr,
        output wbuf_Full, wbuf_Empty, wbuf_Overflow,
        output wbuf_MemWrite, wbuf_Addr, wbuf_Wdata, wbuf_pc,
        output wbuf_LdHit, wbuf_LdData
    );
endinterface

// File: rtl/wbuf.sv
// Posted-store write buffer: in-order FIFO of {pc, addr, data} drained to dm, with load forwarding.
// Latency: a push at edge N is visible on the drain port after N; earliest dm write at edge N+1.
// Backpressure: drains only while DrainEn=1; a push while Full is dropped and sets sticky Overflow.
// Ports: wbuf_clk (rising edge), wbuf_reset (synchronous, active high), bus (wbuf_if.slave).
module wbuf #(
    parameter int DEPTH = 4,   // power of two, >= 2
    parameter int PTRW  = 2    // log2(DEPTH)
) (
    input  logic   wbuf_clk,
    input  logic   wbuf_reset,
    wbuf_if.slave  bus
);

    localparam logic [PTRW-1:0] PTR_ONE  = 1;
    localparam logic [PTRW:0]   CNT_ONE  = 1;
    localparam logic [PTRW:0]   CNT_FULL = DEPTH[PTRW:0];

    logic [PTRW-1:0] rd_q, rd_d;
    logic [PTRW-1:0] wr_q, wr_d;
    logic [PTRW:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;

    // Entry contents carry no reset: validity comes from rd/count alone.
    logic [31:0] pc_q   [DEPTH];
    logic [31:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];

    logic full, empty, push_ok, drain;

    // Flags come straight from registered count, so they are glitch-free.
    assign full    = (cnt_q == CNT_FULL);
    assign empty   = (cnt_q == '0);
    // Full is judged before any same-cycle drain: a push into a full buffer is lost.
    assign push_ok = bus.wbuf_Push && !full;
    assign drain   = bus.wbuf_DrainEn && !empty;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (push_ok) begin
            wr_d = wr_q + PTR_ONE;
        end
        if (drain) begin
            rd_d = rd_q + PTR_ONE;
        end
        case ({push_ok, drain})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        if (bus.wbuf_Push && full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge wbuf_clk) begin
        if (wbuf_reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge wbuf_clk) begin
        if (!wbuf_reset && push_ok) begin
            pc_q[wr_q]   <= bus.wbuf_PushPc;
            addr_q[wr_q] <= bus.wbuf_PushAddr;
            data_q[wr_q] <= bus.wbuf_PushData;
        end
    end

    // Drain port: head entry, forced to zero when nothing is pending.
    assign bus.wbuf_MemWrite = drain;
    assign bus.wbuf_Addr     = empty ? 32'h0 : addr_q[rd_q];
    assign bus.wbuf_Wdata    = empty ? 32'h0 : data_q[rd_q];
    assign bus.wbuf_pc       = empty ? 32'h0 : pc_q[rd_q];
    assign bus.wbuf_Full     = full;
    assign bus.wbuf_Empty    = empty;
    assign bus.wbuf_Overflow = ovf_q;

    // Forwarding: walk entries oldest to youngest so the last match (youngest) wins.
    // The head is still searched while it drains; this cycle's push is not yet stored.
    logic [PTRW-1:0] fw_idx;
    logic [PTRW:0]   fw_age;
    logic            ld_hit;
    logic [31:0]     ld_data;

    always_comb begin
        fw_idx  = '0;
        fw_age  = '0;
        ld_hit  = 1'b0;
        ld_data = 32'h0;
        for (int k = 0; k < DEPTH; k++) begin
            fw_idx = rd_q + k[PTRW-1:0];
            fw_age = k[PTRW:0];
            if ((fw_age < cnt_q) && (addr_q[fw_idx][11:2] == bus.wbuf_LdAddr[11:2])) begin
                ld_hit  = 1'b1;
                ld_data = data_q[fw_idx];
            end
        end
    end

    assign bus.wbuf_LdHit  = ld_hit;
    assign bus.wbuf_LdData = ld_data;

endmodule

// File: tb/tb_wbuf.sv
// Directed bench for wbuf: reset, drain latency, fill/overflow, wrap, forwarding, reset mid-flight.
// Latency: n/a.
// Backpressure: driven directly through DrainEn.
module tb_wbuf;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wbuf_if bus ();

    wbuf #(.DEPTH(4), .PTRW(2)) dut (
        .wbuf_clk   (clk),
        .wbuf_reset (rst),
        .bus        (bus)
    );

    int nvec = 0;
    int nerr = 0;

    // dm model: log of every write accepted at a clock edge.
    logic [31:0] wa_q [$];
    logic [31:0] wd_q [$];
    always @(posedge clk) begin
        if (!rst && bus.wbuf_MemWrite === 1'b1) begin
            wa_q.push_back(bus.wbuf_Addr);
            wd_q.push_back(bus.wbuf_Wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data);
        bus.wbuf_Push     = 1'b1;
        bus.wbuf_PushPc   = pc;
        bus.wbuf_PushAddr = addr;
        bus.wbuf_PushData = data;
    endtask

    task automatic clr_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    initial begin
        bus.wbuf_Push     = 1'b0;
        bus.wbuf_PushPc   = 32'h0;
        bus.wbuf_PushAddr = 32'h0;
        bus.wbuf_PushData = 32'h0;
        bus.wbuf_DrainEn  = 1'b1;
        bus.wbuf_LdAddr   = 32'h0;
        rst = 1'b1;
        cyc();
        cyc();
        // Reset values
        chk1("rst_empty", bus.wbuf_Empty, 1'b1);
        chk1("rst_full", bus.wbuf_Full, 1'b0);
        chk1("rst_ovf", bus.wbuf_Overflow, 1'b0);
        chk1("rst_memwrite", bus.wbuf_MemWrite, 1'b0);
        chk1("rst_ldhit", bus.wbuf_LdHit, 1'b0);
        chk("rst_lddata", bus.wbuf_LdData, 32'h0);
        chk("rst_addr", bus.wbuf_Addr, 32'h0);
        chk("rst_wdata", bus.wbuf_Wdata, 32'h0);
        chk("rst_pc", bus.wbuf_pc, 32'h0);
        rst = 1'b0;

        // T1: basic push then drain, no empty bypass
        set_push(32'd3000, 32'h10, 32'hAAAA5555);
        #1;
        chk1("t1_nobypass", bus.wbuf_MemWrite, 1'b0);
        cyc();
        bus.wbuf_Push = 1'b0;
        #1;
        chk1("t1_memwrite", bus.wbuf_MemWrite, 1'b1);
        chk("t1_addr", bus.wbuf_Addr, 32'h10);
        chk("t1_wdata", bus.wbuf_Wdata, 32'hAAAA5555);
        chk("t1_pc", bus.wbuf_pc, 32'd3000);
        cyc();
        chk1("t1_empty", bus.wbuf_Empty, 1'b1);
        chk1("t1_memwrite_off", bus.wbuf_MemWrite, 1'b0);
        chk("t1_nwrites", 32'(wa_q.size()), 32'd1);
        clr_log();

        // T2: fill, overflow, push into full during drain is still dropped
        bus.wbuf_DrainEn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_push(32'h2000 + 32'(4 * i), 32'(4 * i), 32'h100 + 32'(i));
            cyc();
        end
        bus.wbuf_Push = 1'b0;
        #1;
        chk1("t2_full", bus.wbuf_Full, 1'b1);
        chk1("t2_not_empty", bus.wbuf_Empty, 1'b0);
        chk1("t2_no_ovf_yet", bus.wbuf_Overflow, 1'b0);
        set_push(32'h2010, 32'h20, 32'h555);
        cyc();
        bus.wbuf_Push = 1'b0;
        #1;
        chk1("t2_ovf", bus.wbuf_Overflow, 1'b1);
        chk1("t2_still_full", bus.wbuf_Full, 1'b1);
        chk("t2_head_addr", bus.wbuf_Addr, 32'h0);
        chk("t2_head_data", bus.wbuf_Wdata, 32'h100);
        set_push(32'h2014, 32'h24, 32'h999);
        bus.wbuf_DrainEn = 1'b1;
        cyc();
        bus.wbuf_Push = 1'b0;
        #1;
        chk1("t2_drop_with_drain", bus.wbuf_Full, 1'b0);
        chk("t2_head_after1", bus.wbuf_Addr, 32'h4);
        cyc();
        cyc();
        cyc();
        chk1("t2_empty", bus.wbuf_Empty, 1'b1);
        chk1("t2_ovf_sticky", bus.wbuf_Overflow, 1'b1);
        chk("t2_nwrites", 32'(wa_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_wr_addr", (i < wa_q.size()) ? wa_q[i] : 32'hDEADBEEF, 32'(4 * i));
            chk("t2_wr_data", (i < wd_q.size()) ? wd_q[i] : 32'hDEADBEEF, 32'h100 + 32'(i));
        end
        clr_log();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk1("t2_ovf_cleared", bus.wbuf_Overflow, 1'b0);

        // T3: hold two entries with push+drain every cycle across pointer wrap
        bus.wbuf_DrainEn = 1'b0;
        set_push(32'h3000, 32'hA0, 32'h300);
        cyc();
        set_push(32'h3004, 32'hA4, 32'h301);
        cyc();
        bus.wbuf_DrainEn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_push(32'h3008 + 32'(4 * i), 32'hA8 + 32'(4 * i), 32'h302 + 32'(i));
            #1;
            chk("t3_head", bus.wbuf_Addr, 32'hA0 + 32'(4 * i));
            chk1("t3_full_off", bus.wbuf_Full, 1'b0);
            cyc();
        end
        bus.wbuf_Push = 1'b0;
        #1;
        chk1("t3_two_left", bus.wbuf_Empty, 1'b0);
        cyc();
        cyc();
        chk1("t3_empty", bus.wbuf_Empty, 1'b1);
        chk("t3_nwrites", 32'(wa_q.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            chk("t3_wr_addr", (i < wa_q.size()) ? wa_q[i] : 32'hDEADBEEF, 32'hA0 + 32'(4 * i));
            chk("t3_wr_data", (i < wd_q.size()) ? wd_q[i] : 32'hDEADBEEF, 32'h300 + 32'(i));
        end
        clr_log();

        // T4: forwarding, youngest match, same-cycle push invisible
        bus.wbuf_DrainEn = 1'b0;
        bus.wbuf_LdAddr  = 32'h40;
        set_push(32'h4000, 32'h40, 32'd1);
        #1;
        chk1("t4_push_invisible", bus.wbuf_LdHit, 1'b0);
        cyc();
        set_push(32'h4004, 32'h44, 32'd2);
        cyc();
        set_push(32'h4008, 32'h40, 32'd3);
        #1;
        chk("t4_older_match", bus.wbuf_LdData, 32'd1);
        cyc();
        bus.wbuf_Push = 1'b0;
        #1;
        chk1("t4_hit40", bus.wbuf_LdHit, 1'b1);
        chk("t4_data40", bus.wbuf_LdData, 32'd3);
        bus.wbuf_LdAddr = 32'h42;
        #1;
        chk1("t4_hit42", bus.wbuf_LdHit, 1'b1);
        chk("t4_data42", bus.wbuf_LdData, 32'd3);
        bus.wbuf_LdAddr = 32'h44;
        #1;
        chk("t4_data44", bus.wbuf_LdData, 32'd2);
        bus.wbuf_LdAddr = 32'h48;
        #1;
        chk1("t4_hit48", bus.wbuf_LdHit, 1'b0);
        chk("t4_data48", bus.wbuf_LdData, 32'h0);
        bus.wbuf_DrainEn = 1'b1;
        cyc();
        cyc();
        cyc();
        bus.wbuf_LdAddr = 32'h40;
        #1;
        chk1("t4_drained_nohit", bus.wbuf_LdHit, 1'b0);
        chk1("t4_empty", bus.wbuf_Empty, 1'b1);
        clr_log();

        // T5: forwarding from the head while it drains
        bus.wbuf_DrainEn = 1'b0;
        set_push(32'h5000, 32'h80, 32'd7);
        cyc();
        bus.wbuf_Push    = 1'b0;
        bus.wbuf_LdAddr  = 32'h80;
        bus.wbuf_DrainEn = 1'b1;
        #1;
        chk1("t5_hit", bus.wbuf_LdHit, 1'b1);
        chk("t5_data", bus.wbuf_LdData, 32'd7);
        chk1("t5_memwrite", bus.wbuf_MemWrite, 1'b1);
        cyc();
        chk1("t5_hit_gone", bus.wbuf_LdHit, 1'b0);
        chk("t5_data_gone", bus.wbuf_LdData, 32'h0);
        chk("t5_dm_addr", (wa_q.size() > 0) ? wa_q[0] : 32'hDEADBEEF, 32'h80);
        chk("t5_dm_data", (wd_q.size() > 0) ? wd_q[0] : 32'hDEADBEEF, 32'd7);
        clr_log();

        // T6: reset with pending stores and a concurrent push
        bus.wbuf_DrainEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_push(32'h6000 + 32'(4 * i), 32'hC0 + 32'(4 * i), 32'h600 + 32'(i));
            cyc();
        end
        set_push(32'h600C, 32'hCC, 32'h603);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.wbuf_Push    = 1'b0;
        bus.wbuf_DrainEn = 1'b1;
        bus.wbuf_LdAddr  = 32'hC0;
        #1;
        chk1("t6_empty", bus.wbuf_Empty, 1'b1);
        chk1("t6_full", bus.wbuf_Full, 1'b0);
        chk1("t6_ovf", bus.wbuf_Overflow, 1'b0);
        chk1("t6_memwrite", bus.wbuf_MemWrite, 1'b0);
        chk1("t6_ldhit", bus.wbuf_LdHit, 1'b0);
        chk("t6_addr", bus.wbuf_Addr, 32'h0);
        cyc();
        cyc();
        cyc();
        chk("t6_no_dm_writes", 32'(wa_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
